// File: rtl/irq_controller_if.sv
// irq_controller_if
//   Bus between the interrupt controller and core0 / configuration master.
//   Signals:
//     i_cfg_we     register write strobe (one cycle)
//     i_cfg_addr   register select: 0 MASK, 1 EDGE, 2 PENDING, 3 STATUS
//     i_cfg_wdata  register write data
//     o_cfg_rdata  combinational read data of the addressed register
//     o_int_req    interrupt request to the core
//     o_int_id     index of the requested / in-service line
//     i_int_ack    core accepts the current request
//     i_eoi        core signals end of interrupt
//   Modports: master = core / config side, slave = irq_controller.
interface irq_controller_if;
  logic        i_cfg_we;
  logic [1:0]  i_cfg_addr;
  logic [31:0] i_cfg_wdata;
  logic [31:0] o_cfg_rdata;
  logic        o_int_req;
  logic [2:0]  o_int_id;
  logic        i_int_ack;
  logic        i_eoi;

  modport master (
    output i_cfg_we, i_cfg_addr, i_cfg_wdata, i_int_ack, i_eoi,
    input  o_cfg_rdata, o_int_req, o_int_id
  );

  modport slave (
    input  i_cfg_we, i_cfg_addr, i_cfg_wdata, i_int_ack, i_eoi,
    output o_cfg_rdata, o_int_req, o_int_id
  );
endinterface

// File: rtl/irq_controller.sv
// irq_controller
//   Synchronizes raw interrupt lines, captures them per line in edge or
//   level mode, masks them, picks the lowest-index candidate and runs a
//   request / acknowledge / end-of-interrupt handshake with core0.
//   Ports:
//     clk             system clock, rising edge
//     reset           asynchronous active-low reset
//     i_interruption  raw asynchronous interrupt lines [NUM_IRQ-1:0]
//     bus             irq_controller_if.slave (config registers + handshake)
module irq_controller #(
  parameter int NUM_IRQ     = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] i_interruption,
  irq_controller_if.slave    bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0] synced, prev, rise;
  logic [NUM_IRQ-1:0] mask, edge_mode;
  logic [NUM_IRQ-1:0] pending, pending_next;
  logic [NUM_IRQ-1:0] in_service, in_service_next;
  logic [NUM_IRQ-1:0] cand, id_oh, wdata_n;
  logic [2:0]         id, id_next, cand_id;
  logic               wr_mask, wr_edge, wr_pend, ack_fire;
  logic [31:0]        rdata;
  logic               unused_wdata;

  assign wdata_n      = bus.i_cfg_wdata[NUM_IRQ-1:0];
  assign unused_wdata = ^bus.i_cfg_wdata[31:NUM_IRQ];
  assign wr_mask      = bus.i_cfg_we && (bus.i_cfg_addr == 2'd0);
  assign wr_edge      = bus.i_cfg_we && (bus.i_cfg_addr == 2'd1);
  assign wr_pend      = bus.i_cfg_we && (bus.i_cfg_addr == 2'd2);

  assign synced   = sync_q[SYNC_STAGES-1];
  assign rise     = synced & ~prev;
  assign cand     = pending & mask;
  assign ack_fire = (state == REQ) && bus.i_int_ack;

  // One-hot of the latched id, and lowest-index candidate (line 0 wins).
  always_comb begin
    id_oh   = '0;
    cand_id = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      id_oh[k] = (id == 3'(k));
    end
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (cand[k]) cand_id = 3'(k);
    end
  end

  // A change of mode drops the pending bit for one cycle so it is rebuilt
  // from scratch under the new mode. In edge mode a new edge beats W1C/ack.
  always_comb begin
    pending_next = pending;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (wr_edge && (wdata_n[k] != edge_mode[k])) begin
        pending_next[k] = 1'b0;
      end else if (edge_mode[k]) begin
        pending_next[k] = rise[k] |
          (pending[k] & ~((ack_fire & id_oh[k]) | (wr_pend & wdata_n[k])));
      end else begin
        pending_next[k] = synced[k];
      end
    end
  end

  always_comb begin
    state_next      = state;
    id_next         = id;
    in_service_next = in_service;
    case (state)
      IDLE: begin
        if (|cand) begin
          id_next    = cand_id;
          state_next = REQ;
        end
      end
      REQ: begin
        // Ack wins over a simultaneous withdrawal.
        if (bus.i_int_ack) begin
          in_service_next = in_service | id_oh;
          state_next      = SERVICE;
        end else if (!(|(mask & id_oh)) || !(|(pending & id_oh))) begin
          id_next    = '0;
          state_next = IDLE;
        end
      end
      SERVICE: begin
        if (bus.i_eoi) begin
          in_service_next = in_service & ~id_oh;
          id_next         = '0;
          state_next      = IDLE;
        end
      end
      default: begin
        id_next    = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      prev       <= '0;
      mask       <= '0;
      edge_mode  <= '0;
      pending    <= '0;
      in_service <= '0;
      id         <= '0;
      state      <= IDLE;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], i_interruption};
      prev       <= synced;
      pending    <= pending_next;
      in_service <= in_service_next;
      id         <= id_next;
      state      <= state_next;
      if (wr_mask) mask      <= wdata_n;
      if (wr_edge) edge_mode <= wdata_n;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.i_cfg_addr)
      2'd0: rdata[NUM_IRQ-1:0] = mask;
      2'd1: rdata[NUM_IRQ-1:0] = edge_mode;
      2'd2: rdata[NUM_IRQ-1:0] = pending;
      default: begin
        rdata[NUM_IRQ-1:0] = in_service;
        rdata[10:8]        = id;
        rdata[13:12]       = state;
      end
    endcase
  end

  assign bus.o_cfg_rdata = rdata;
  assign bus.o_int_req   = (state == REQ);
  assign bus.o_int_id    = id;

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller between the MotherBoard `i_interruption[4:0]` lines and core0.
- Synchronizes and captures external interrupt lines, supporting per-line edge or level mode.
- Applies a mask and arbitrates by fixed priority.
- Sequences a request/acknowledge/end-of-interrupt handshake with the core.
- Exposes a small register interface for configuration and status.

Parameters:
- NUM_IRQ, 5, number of interrupt lines (max 8).
- SYNC_STAGES, 2, synchronizer flops per input line (min 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- i_interruption  input  NUM_IRQ  raw asynchronous interrupt lines.
- i_cfg_we  input  1  register write strobe, single cycle.
- i_cfg_addr  input  2  register select: 0 MASK, 1 EDGE, 2 PENDING, 3 STATUS.
- i_cfg_wdata  input  32  write data; bits above NUM_IRQ ignored.
- o_cfg_rdata  output  32  combinational read of the addressed register.
- o_int_req  output  1  interrupt request to core.
- o_int_id  output  3  index of the requested/in-service line.
- i_int_ack  input  1  core accepts the current request.
- i_eoi  input  1  core signals end of interrupt.

Behaviour:
- Reset (reset=0, asynchronous):
  - MASK, EDGE, PENDING, IN_SERVICE, synchronizers and edge-history are all cleared to 0.
  - FSM goes to IDLE; o_int_req=0, o_int_id=0.
- Sync and capture:
  - Each line passes through SYNC_STAGES flops; the prior synced value is kept for edge detection.
  - EDGE[k]=1 (edge mode): PENDING[k] is set on a synced 0->1 transition. It is cleared only by core ack of line k or by a write-1-to-clear to PENDING.
  - EDGE[k]=0 (level mode): PENDING[k] equals the synced level. Ack and W1C have no effect on it.
  - A set event and a W1C in the same cycle: set wins.
- Latency: line high before clock edge E0 → PENDING set after edge E(SYNC_STAGES) → o_int_req high after edge E(SYNC_STAGES+1), provided the FSM is IDLE and the line is unmasked.
- Arbitration: candidate = lowest index k with PENDING[k] & MASK[k]. Line 0 has highest priority.
- FSM:
  - IDLE:
    - If a candidate exists, latch it into o_int_id and go to REQ.
  - REQ (o_int_req=1):
    - o_int_id is stable; a later higher-priority arrival does not preempt.
    - If i_int_ack: set IN_SERVICE[id], clear PENDING[id] if edge mode, drop o_int_req, go to SERVICE.
    - Else if MASK[id] becomes 0, or PENDING[id] drops (level line deasserted / W1C): withdraw, go to IDLE.
    - Ack takes precedence over withdrawal in the same cycle.
  - SERVICE (o_int_req=0, o_int_id holds):
    - On i_eoi: clear IN_SERVICE[id], go to IDLE. Next candidate may request on the following cycle.
    - New pending events are still captured during SERVICE; no nesting.
- Ignored inputs:
  - i_int_ack outside REQ is ignored.
  - i_eoi outside SERVICE is ignored.
  - i_eoi together with i_int_ack in REQ: ack is processed, eoi is ignored.
- Registers:
  - MASK and EDGE are read/write and take effect the cycle after the write.
  - PENDING: read gives the current value; write is W1C for edge-mode bits only.
  - STATUS (read-only):
    - bits[NUM_IRQ-1:0] = IN_SERVICE.
    - bits[10:8] = o_int_id.
    - bits[13:12] = FSM state (0 IDLE, 1 REQ, 2 SERVICE).
    - Writes are ignored.
  - Unused read bits are 0.
- Changing EDGE[k] while pending: PENDING[k] is cleared and recomputed under the new mode the next cycle.
- Reset mid-handshake: all state is cleared immediately; o_int_req falls asynchronously.

Test Plan:
- Edge capture and latency:
  - Stimulus: reset, MASK=0x1F, EDGE=0x1F; pulse i_interruption[2] for 1 cycle.
  - Required: o_int_req rises 3 edges later with o_int_id=2.
  - Required after i_int_ack: PENDING=0, STATUS[2]=1.
  - Required after i_eoi: STATUS=0, state IDLE.
- Priority without preemption:
  - Stimulus: lines 3 and 1 fire simultaneously.
  - Required: id=1 first; after ack/eoi, id=3 requested on the next cycle.
  - Stimulus: line 0 fires while id=3 is in REQ.
  - Required: id stays 3 until ack; line 0 is served next.
- Level mode:
  - Stimulus: EDGE=0, hold line 4 high through ack and eoi.
  - Required: re-request of id=4 one cycle after eoi.
  - Stimulus: drop line 4 during REQ.
  - Required: o_int_req withdrawn within SYNC_STAGES+1 cycles, state IDLE.
- Mask and W1C:
  - Stimulus: MASK=0x00, edge fires on line 0.
  - Required: PENDING=0x01, no o_int_req.
  - Stimulus: set MASK=0x01.
  - Required: request id=0 one cycle later.
  - Stimulus: instead, write PENDING=0x01 in the same cycle as a new edge.
  - Required: bit stays set.
- Async reset mid-operation:
  - Stimulus: assert reset=0 while in SERVICE with PENDING=0x06.
  - Required: o_int_req=0 immediately; all registers read 0 after release.
